packet_serializer_bch: RTL and testbench
========================================

Name: packet_serializer_bch

Overview:
- Next-generation data-island packet serializer for the HDMI TX path: accepts whole packets (24-bit header plus NUM_SUB 56-bit subpackets) over a valid/ready handshake and buffers one in a pending slot.
- Serialises each packet over 32 pixel clocks with on-the-fly BCH ECC.
- Emits an all-zero null packet and flags underrun when an island slot has no packet ready.
- Sits between the packet sources/arbiter and the TERC4 encoders.

Parameters:
- NUM_SUB, 4, subpackets per packet (1..4); packet_data width is 2*NUM_SUB+1.
- ECC_POLY, 8'h83, reflected BCH feedback mask applied when (ecc[0] ^ bit) is 1.

Ports:
- clk_pixel  input  1  pixel clock.
- reset  input  1  synchronous, active-high reset.
- data_island_period  input  1  high during each data-island pixel; asserted in runs that are multiples of 32.
- in_valid  input  1  packet offered.
- in_ready  output  1  pending slot free.
- in_header  input  24  header bytes HB0..HB2, LSB first.
- in_sub  input  NUM_SUB x 56  subpacket data, LSB first.
- packet_data  output  2*NUM_SUB+1  bit0 = header lane; bits[NUM_SUB:1] = even bits of subpackets; bits[2*NUM_SUB:NUM_SUB+1] = odd bits.
- counter  output  5  pixel index within the packet, 0..31.
- packet_start  output  1  high when counter==0 and data_island_period.
- underrun  output  1  one-cycle pulse when a null packet begins.

Behaviour:
- Reset: counter=0, all parity=0, pending empty, state EMPTY, in_ready=0 during reset and 1 on the first cycle after reset, underrun=0, packet_data=0.
- Handshake:
  - in_ready = !pending_full.
  - A transfer (in_valid & in_ready) captures header/sub into pending next cycle.
  - in_valid held while not ready must keep its data stable.
- States:
  - EMPTY (no active packet) -> LOADED when pending_full; pending moves to active and the slot frees the same edge.
  - LOADED -> SENDING when data_island_period & counter==0.
  - EMPTY -> SENDING_NULL when data_island_period & counter==0; underrun pulses that cycle.
  - SENDING/SENDING_NULL -> EMPTY at counter==31 & data_island_period.
  - If pending_full at that edge, go directly to LOADED; pending moves to active.
- Counter: increments by 1 mod 32 on each data_island_period cycle. It holds when data_island_period is low; a packet interrupted mid-way resumes from the held counter.
- Serialisation has zero latency:
  - packet_data is combinational from registered active data, parity and counter.
  - Header lane bit = {parity4, header}[counter].
  - Subpacket lane k even/odd bits = {parity_k, sub_k}[2*counter] / [2*counter+1].
  - In SENDING_NULL, or whenever data_island_period is low, all source data reads as 0. A null packet is therefore all zeros including ECC.
- ECC:
  - next(e,b) = (e>>1) ^ ((e[0]^b) ? ECC_POLY : 0).
  - Subpacket parity advances two bits per cycle while counter<28.
  - Header parity advances one bit per cycle while counter<24.
  - All parity clears at counter==31.
  - Parity bits are transmitted after the data bits: counter 24..31 on the header lane, 28..31 on the subpacket lanes.
- Simultaneous events: a transfer into pending on the same edge as pending->active is legal only if pending was empty before that edge (in_ready is registered-state based), so no loss.
- Reset mid-packet aborts the packet; after reset the output is zeros and the next packet starts at counter 0.
- in_sub lanes at index >= NUM_SUB do not exist; no port is padded.

Decomposition:
- Package hdmi_packet_pkg holds:
  - HEADER_BITS=24, SUB_BITS=56, ECC_BITS=8, PACKET_PIXELS=32;
  - the packet_t struct (header, sub array);
  - the function bch_next_ecc(ecc, bit, poly).
- One sub-module, bch_ecc_lane: a parity register with 1- or 2-bit-per-cycle advance (parameter BITS_PER_CYCLE), clear and enable. It is instantiated NUM_SUB times with 2 and once with 1.

Test Plan:
- Header 24'h000001, subs 0, sent at counter 0..31 -> header lane bits 0..23 = 1 then 23 zeros; bits 24..31 = 8'h4A LSB first; all subpacket lanes 0 including parity.
- No packet offered, data_island_period high for 32 cycles -> underrun=1 only at counter 0; packet_data=0 for all 32 cycles; counter wraps 31->0.
- Three packets offered back-to-back with in_valid held and data_island_period high for 96 cycles -> in_ready drops after the first capture; three packets sent contiguously with no underrun; the ECC of each matches the golden model.
- data_island_period dropped at counter 10 for 5 cycles, then restored -> counter holds 10, output 0 while low, and the packet completes with correct ECC.
- reset asserted at counter 17 -> next cycle counter=0, parity=0, pending empty, in_ready=1 after release; the following packet is correct.
- NUM_SUB=1 build, sub0=56'h1 -> packet_data width 3; subpacket ECC at counter 28..31 matches the golden model; the even lane carries bit0=1 at counter 0.

Source files
------------

// File: rtl/packet_serializer_bch_pkg.sv
// Shared constants, types and the BCH step function for the HDMI data-island packet path.
package hdmi_packet_pkg;
  localparam int HEADER_BITS   = 24;
  localparam int SUB_BITS      = 56;
  localparam int ECC_BITS      = 8;
  localparam int PACKET_PIXELS = 32;
  localparam int MAX_SUB       = 4;

  typedef struct packed {
    logic [HEADER_BITS-1:0]           header;
    logic [MAX_SUB-1:0][SUB_BITS-1:0] sub;
  } packet_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_LOADED,
    ST_SENDING,
    ST_SENDING_NULL
  } ser_state_t;

  // One LSB-first step of the reflected BCH parity register.
  function automatic logic [ECC_BITS-1:0] bch_next_ecc(
    input logic [ECC_BITS-1:0] ecc,
    input logic                data_bit,
    input logic [ECC_BITS-1:0] poly
  );
    return (ecc >> 1) ^ ((ecc[0] ^ data_bit) ? poly : '0);
  endfunction
endpackage

// File: rtl/packet_serializer_bch_ecc_lane.sv
// BCH parity register absorbing BITS_PER_CYCLE data bits per enabled cycle, lowest index first.
module bch_ecc_lane
  import hdmi_packet_pkg::*;
#(
  parameter int                  BITS_PER_CYCLE = 1,
  parameter logic [ECC_BITS-1:0] POLY           = 8'h83
) (
  input  logic                      clk,
  input  logic                      i_reset,
  input  logic                      i_clear,
  input  logic                      i_en,
  input  logic [BITS_PER_CYCLE-1:0] i_bits,
  output logic [ECC_BITS-1:0]       o_parity
);
  logic [ECC_BITS-1:0] r_parity;
  logic [ECC_BITS-1:0] w_next;

  always_comb begin
    w_next = r_parity;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      w_next = bch_next_ecc(w_next, i_bits[i], POLY);
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset || i_clear) begin
      r_parity <= '0;
    end else if (i_en) begin
      r_parity <= w_next;
    end
  end

  assign o_parity = r_parity;
endmodule

// File: rtl/packet_serializer_bch.sv
// Data-island packet serializer: one pending slot, one active packet, 32-pixel
// serialisation with on-the-fly BCH parity and null-packet fill on underrun.
module packet_serializer_bch
  import hdmi_packet_pkg::*;
#(
  parameter int                  NUM_SUB  = 4,
  parameter logic [ECC_BITS-1:0] ECC_POLY = 8'h83
) (
  input  logic                              clk_pixel,
  input  logic                              reset,
  input  logic                              data_island_period,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [HEADER_BITS-1:0]            in_header,
  input  logic [NUM_SUB-1:0][SUB_BITS-1:0]  in_sub,
  output logic [2*NUM_SUB:0]                packet_data,
  output logic [4:0]                        counter,
  output logic                              packet_start,
  output logic                              underrun
);
  ser_state_t                       r_state;
  logic [4:0]                       r_counter;
  logic                             r_pend_full;
  logic [HEADER_BITS-1:0]           r_pend_header;
  logic [HEADER_BITS-1:0]           r_act_header;
  logic [NUM_SUB-1:0][SUB_BITS-1:0] r_pend_sub;
  logic [NUM_SUB-1:0][SUB_BITS-1:0] r_act_sub;

  logic                              w_take;
  logic                              w_slot_start;
  logic                              w_slot_end;
  logic                              w_src_on;
  logic [ECC_BITS-1:0]               w_hdr_parity;
  logic [HEADER_BITS+ECC_BITS-1:0]   w_hdr_word;
  logic                              w_hdr_bit;
  logic [NUM_SUB-1:0]                w_even;
  logic [NUM_SUB-1:0]                w_odd;

  assign in_ready     = !r_pend_full && !reset;
  assign w_take       = in_valid && in_ready;
  assign w_slot_start = data_island_period && (r_counter == 5'd0);
  assign w_slot_end   = data_island_period && (r_counter == 5'd31);
  // Source data is visible only while a real packet owns the slot and the island is active.
  assign w_src_on     = data_island_period && (r_state == ST_LOADED || r_state == ST_SENDING);

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_counter   <= '0;
      r_pend_full <= 1'b0;
    end else begin
      if (data_island_period) begin
        r_counter <= r_counter + 5'd1;
      end
      if (w_take) begin
        r_pend_full   <= 1'b1;
        r_pend_header <= in_header;
        r_pend_sub    <= in_sub;
      end
      case (r_state)
        ST_EMPTY: begin
          if (w_slot_start) begin
            r_state <= ST_SENDING_NULL;
          end else if (r_pend_full) begin
            r_state      <= ST_LOADED;
            r_act_header <= r_pend_header;
            r_act_sub    <= r_pend_sub;
            r_pend_full  <= 1'b0;
          end
        end
        ST_LOADED: begin
          if (w_slot_start) r_state <= ST_SENDING;
        end
        default: begin
          if (w_slot_end) begin
            if (r_pend_full) begin
              r_state      <= ST_LOADED;
              r_act_header <= r_pend_header;
              r_act_sub    <= r_pend_sub;
              r_pend_full  <= 1'b0;
            end else begin
              r_state <= ST_EMPTY;
            end
          end
        end
      endcase
    end
  end

  assign w_hdr_word = {w_hdr_parity, r_act_header};
  assign w_hdr_bit  = w_src_on & w_hdr_word[r_counter];

  bch_ecc_lane #(
    .BITS_PER_CYCLE(1),
    .POLY          (ECC_POLY)
  ) u_hdr_ecc (
    .clk     (clk_pixel),
    .i_reset (reset),
    .i_clear (w_slot_end),
    .i_en    (data_island_period && (r_counter < 5'd24)),
    .i_bits  (w_hdr_bit),
    .o_parity(w_hdr_parity)
  );

  for (genvar gi = 0; gi < NUM_SUB; gi++) begin : g_sub
    logic [ECC_BITS-1:0]          w_parity;
    logic [SUB_BITS+ECC_BITS-1:0] w_word;

    assign w_word     = {w_parity, r_act_sub[gi]};
    assign w_even[gi] = w_src_on & w_word[{r_counter, 1'b0}];
    assign w_odd[gi]  = w_src_on & w_word[{r_counter, 1'b1}];

    bch_ecc_lane #(
      .BITS_PER_CYCLE(2),
      .POLY          (ECC_POLY)
    ) u_sub_ecc (
      .clk     (clk_pixel),
      .i_reset (reset),
      .i_clear (w_slot_end),
      .i_en    (data_island_period && (r_counter < 5'd28)),
      .i_bits  ({w_odd[gi], w_even[gi]}),
      .o_parity(w_parity)
    );
  end

  assign packet_data  = {w_odd, w_even, w_hdr_bit};
  assign counter      = r_counter;
  assign packet_start = w_slot_start;
  assign underrun     = w_slot_start && (r_state == ST_EMPTY);
endmodule

// File: tb/tb_packet_serializer_bch.sv
// Scoreboard bench for packet_serializer_bch: a 4-subpacket and a 1-subpacket instance.
module tb_packet_serializer_bch;
  logic clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  logic             reset = 1'b1;
  logic             dip = 1'b0, in_valid = 1'b0, in_ready;
  logic [23:0]      in_header = '0;
  logic [3:0][55:0] in_sub = '0;
  logic [8:0]       packet_data;
  logic [4:0]       counter;
  logic             packet_start, underrun;

  logic             dip1 = 1'b0, in_valid1 = 1'b0, in_ready1;
  logic [23:0]      in_header1 = '0;
  logic [0:0][55:0] in_sub1 = '0;
  logic [2:0]       packet_data1;
  logic [4:0]       counter1;
  logic             packet_start1, underrun1;

  packet_serializer_bch #(.NUM_SUB(4), .ECC_POLY(8'h83)) dut (
    .clk_pixel(clk_pixel), .reset(reset), .data_island_period(dip),
    .in_valid(in_valid), .in_ready(in_ready), .in_header(in_header), .in_sub(in_sub),
    .packet_data(packet_data), .counter(counter), .packet_start(packet_start), .underrun(underrun)
  );

  packet_serializer_bch #(.NUM_SUB(1), .ECC_POLY(8'h83)) dut1 (
    .clk_pixel(clk_pixel), .reset(reset), .data_island_period(dip1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_header(in_header1), .in_sub(in_sub1),
    .packet_data(packet_data1), .counter(counter1), .packet_start(packet_start1), .underrun(underrun1)
  );

  int total = 0;
  int bad   = 0;

  logic [8:0] exp_q[$];
  logic [2:0] exp1_q[$];

  logic [8:0] s_pd;
  logic [4:0] s_cnt;
  logic       s_start, s_und, s_rdy;
  logic [2:0] s_pd1;
  logic [4:0] s_cnt1;
  logic       s_rdy1;

  function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic b);
    return (e >> 1) ^ ((e[0] ^ b) ? 8'h83 : 8'h00);
  endfunction

  // Golden model: push the 32 expected packet_data words of one packet.
  task automatic push_pkt(input logic [23:0] h, input logic [3:0][55:0] s, input int nsub);
    logic [7:0]  he;
    logic [7:0]  se;
    logic [31:0] hw;
    logic [63:0] sw [4];
    logic [8:0]  w;
    he = '0;
    for (int i = 0; i < 24; i++) he = ecc_step(he, h[i]);
    hw = {he, h};
    for (int k = 0; k < 4; k++) begin
      se = '0;
      for (int i = 0; i < 56; i++) se = ecc_step(se, s[k][i]);
      sw[k] = {se, s[k]};
    end
    for (int c = 0; c < 32; c++) begin
      w = '0;
      w[0] = hw[c];
      for (int k = 0; k < nsub; k++) begin
        w[1 + k]        = sw[k][2 * c];
        w[1 + nsub + k] = sw[k][2 * c + 1];
      end
      if (nsub == 4) exp_q.push_back(w);
      else exp1_q.push_back(w[2:0]);
    end
  endtask

  // Drive island enables for one cycle and sample all outputs on the falling edge.
  task automatic step(input logic d, input logic d1);
    dip  = d;
    dip1 = d1;
    @(negedge clk_pixel);
    s_pd = packet_data;   s_cnt = counter;   s_start = packet_start;
    s_und = underrun;     s_rdy = in_ready;
    s_pd1 = packet_data1; s_cnt1 = counter1; s_rdy1 = in_ready1;
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic offer(input logic [23:0] h, input logic [3:0][55:0] s, output bit ok);
    in_header = h;
    in_sub    = s;
    in_valid  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      step(1'b0, 1'b0);
      ok = s_rdy;
    end
    in_valid = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  function automatic logic [3:0][55:0] rand_subs();
    logic [3:0][55:0] s;
    for (int k = 0; k < 4; k++) s[k] = {24'($urandom), $urandom};
    return s;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    step(1'b0, 1'b0);
    total++;
    if (s_rdy !== 1'b0) begin bad++; $display("FAIL reset_ready_low got=%b want=0", s_rdy); end
    step(1'b0, 1'b0);
    reset = 1'b0;
    step(1'b0, 1'b0);
    total++;
    if (s_cnt !== 5'd0) begin bad++; $display("FAIL reset_counter got=%0d want=0", s_cnt); end
    total++;
    if (s_pd !== 9'd0) begin bad++; $display("FAIL reset_packet_data got=%h want=000", s_pd); end
    total++;
    if (s_und !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b want=0", s_und); end
    total++;
    if (s_rdy !== 1'b1) begin bad++; $display("FAIL reset_ready_high got=%b want=1", s_rdy); end
    $display("reset: counter=%0d data=%h ready=%b", s_cnt, s_pd, s_rdy);
  endtask

  task automatic test_header_only();
    logic [31:0] hw;
    logic [8:0]  exp;
    bit          ok;
    hw = {8'h4A, 24'h000001};
    offer(24'h000001, '0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL hdr_handshake got=0 want=1"); end
    for (int c = 0; c < 32; c++) exp_q.push_back({8'b0, hw[c]});
    for (int c = 0; c < 32; c++) begin
      step(1'b1, 1'b0);
      exp = exp_q.pop_front();
      total++;
      if (s_pd !== exp) begin bad++; $display("FAIL hdr_data c=%0d got=%h want=%h", c, s_pd, exp); end
      total++;
      if (s_cnt !== 5'(c)) begin bad++; $display("FAIL hdr_counter got=%0d want=%0d", s_cnt, c); end
      total++;
      if (s_start !== (c == 0)) begin bad++; $display("FAIL hdr_start c=%0d got=%b", c, s_start); end
      total++;
      if (s_und !== 1'b0) begin bad++; $display("FAIL hdr_underrun c=%0d got=%b want=0", c, s_und); end
    end
    $display("header_only: packet of header 000001 sent, parity 4A expected");
  endtask

  task automatic test_null();
    for (int c = 0; c < 32; c++) begin
      step(1'b1, 1'b0);
      total++;
      if (s_pd !== 9'd0) begin bad++; $display("FAIL null_data c=%0d got=%h want=000", c, s_pd); end
      total++;
      if (s_und !== (c == 0)) begin bad++; $display("FAIL null_underrun c=%0d got=%b", c, s_und); end
      total++;
      if (s_cnt !== 5'(c)) begin bad++; $display("FAIL null_counter got=%0d want=%0d", s_cnt, c); end
    end
    step(1'b0, 1'b0);
    total++;
    if (s_cnt !== 5'd0) begin bad++; $display("FAIL null_wrap got=%0d want=0", s_cnt); end
    $display("null: 32 zero pixels, counter wrapped to %0d", s_cnt);
  endtask

  task automatic test_back_to_back();
    logic [23:0]      h [3];
    logic [3:0][55:0] s [3];
    logic [8:0]       exp;
    int               idx;
    bit               chk_rdy;
    for (int k = 0; k < 3; k++) begin
      h[k] = 24'($urandom);
      s[k] = rand_subs();
    end
    idx = 0;
    chk_rdy = 1'b0;
    in_header = h[0];
    in_sub = s[0];
    in_valid = 1'b1;
    for (int i = 0; i < 20 && idx < 2; i++) begin
      step(1'b0, 1'b0);
      if (chk_rdy) begin
        total++;
        if (s_rdy !== 1'b0) begin bad++; $display("FAIL b2b_ready_drop got=%b want=0", s_rdy); end
      end
      chk_rdy = 1'b0;
      if (s_rdy) begin
        push_pkt(h[idx], s[idx], 4);
        idx++;
        chk_rdy = 1'b1;
        in_header = h[idx];
        in_sub = s[idx];
      end
    end
    total++;
    if (idx != 2) begin bad++; $display("FAIL b2b_preload got=%0d want=2", idx); end
    for (int c = 0; c < 96; c++) begin
      step(1'b1, 1'b0);
      if (chk_rdy) begin
        total++;
        if (s_rdy !== 1'b0) begin bad++; $display("FAIL b2b_ready_drop got=%b want=0", s_rdy); end
      end
      chk_rdy = 1'b0;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL b2b_queue c=%0d got=empty want=entry", c);
      end else begin
        exp = exp_q.pop_front();
        total++;
        if (s_pd !== exp) begin bad++; $display("FAIL b2b_data c=%0d got=%h want=%h", c, s_pd, exp); end
      end
      total++;
      if (s_und !== 1'b0) begin bad++; $display("FAIL b2b_underrun c=%0d got=%b want=0", c, s_und); end
      total++;
      if (s_cnt !== 5'(c % 32)) begin bad++; $display("FAIL b2b_counter got=%0d want=%0d", s_cnt, c % 32); end
      if (in_valid && s_rdy) begin
        push_pkt(h[idx], s[idx], 4);
        idx++;
        chk_rdy = 1'b1;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    total++;
    if (idx != 3 || exp_q.size() != 0) begin
      bad++; $display("FAIL b2b_done got=%0d/%0d want=3/0", idx, exp_q.size());
    end
    $display("back_to_back: %0d packets sent contiguously", idx);
  endtask

  task automatic test_gap();
    logic [8:0] exp;
    bit         ok;
    logic [23:0] h;
    logic [3:0][55:0] s;
    h = 24'($urandom);
    s = rand_subs();
    offer(h, s, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL gap_handshake got=0 want=1"); end
    push_pkt(h, s, 4);
    for (int c = 0; c < 32; c++) begin
      if (c == 10) begin
        for (int i = 0; i < 5; i++) begin
          step(1'b0, 1'b0);
          total++;
          if (s_cnt !== 5'd10) begin bad++; $display("FAIL gap_hold got=%0d want=10", s_cnt); end
          total++;
          if (s_pd !== 9'd0) begin bad++; $display("FAIL gap_quiet got=%h want=000", s_pd); end
        end
      end
      step(1'b1, 1'b0);
      exp = exp_q.pop_front();
      total++;
      if (s_pd !== exp) begin bad++; $display("FAIL gap_data c=%0d got=%h want=%h", c, s_pd, exp); end
    end
    $display("gap: packet resumed at counter 10 and completed");
  endtask

  task automatic test_reset_mid();
    logic [8:0] exp;
    bit         ok;
    logic [23:0] h;
    logic [3:0][55:0] s;
    h = 24'($urandom);
    s = rand_subs();
    offer(h, s, ok);
    push_pkt(h, s, 4);
    for (int c = 0; c < 17; c++) begin
      step(1'b1, 1'b0);
      exp = exp_q.pop_front();
      total++;
      if (s_pd !== exp) begin bad++; $display("FAIL rmid_pre c=%0d got=%h want=%h", c, s_pd, exp); end
    end
    exp_q.delete();
    reset = 1'b1;
    step(1'b0, 1'b0);
    total++;
    if (s_rdy !== 1'b0) begin bad++; $display("FAIL rmid_ready_low got=%b want=0", s_rdy); end
    reset = 1'b0;
    step(1'b0, 1'b0);
    total++;
    if (s_cnt !== 5'd0) begin bad++; $display("FAIL rmid_counter got=%0d want=0", s_cnt); end
    total++;
    if (s_pd !== 9'd0) begin bad++; $display("FAIL rmid_data got=%h want=000", s_pd); end
    total++;
    if (s_rdy !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b want=1", s_rdy); end
    h = 24'($urandom);
    s = rand_subs();
    offer(h, s, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rmid_handshake got=0 want=1"); end
    push_pkt(h, s, 4);
    for (int c = 0; c < 32; c++) begin
      step(1'b1, 1'b0);
      exp = exp_q.pop_front();
      total++;
      if (s_pd !== exp) begin bad++; $display("FAIL rmid_post c=%0d got=%h want=%h", c, s_pd, exp); end
    end
    $display("reset_mid: aborted at counter 17, next packet sent");
  endtask

  task automatic test_num_sub1();
    logic [2:0]       exp;
    bit               ok;
    logic [3:0][55:0] s;
    s = '0;
    s[0] = 56'h1;
    in_header1 = 24'($urandom);
    in_sub1[0] = 56'h1;
    in_valid1 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      step(1'b0, 1'b0);
      ok = s_rdy1;
    end
    in_valid1 = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL ns1_handshake got=0 want=1"); end
    push_pkt(in_header1, s, 1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int c = 0; c < 32; c++) begin
      step(1'b0, 1'b1);
      exp = exp1_q.pop_front();
      total++;
      if (s_pd1 !== exp) begin bad++; $display("FAIL ns1_data c=%0d got=%h want=%h", c, s_pd1, exp); end
      total++;
      if (s_cnt1 !== 5'(c)) begin bad++; $display("FAIL ns1_counter got=%0d want=%0d", s_cnt1, c); end
      if (c == 0) begin
        total++;
        if (s_pd1[1] !== 1'b1) begin bad++; $display("FAIL ns1_even_bit0 got=%b want=1", s_pd1[1]); end
      end
    end
    $display("num_sub1: 3-lane packet with sub0=1 sent");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_header_only();
    test_null();
    test_back_to_back();
    test_gap();
    test_reset_mid();
    test_num_sub1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
